// File: rtl/seq_modulus_pkg.sv
// Shared state encoding for the sequential modulus/divide unit.
package seq_modulus_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/seq_modulus_mod_step.sv
// Single combinational restoring-division step: shift in one dividend bit,
// conditionally subtract the divisor, emit one quotient bit.
module mod_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] dsr_i,
    output logic [WIDTH:0]   rem_o,
    output logic             qbit_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] dsr_ext;

    always_comb begin
        shifted = {rem_i[WIDTH-1:0], bit_i};
        dsr_ext = {1'b0, dsr_i};
        // rem_i stays below the divisor, so its top bit is a zero guard bit
        qbit_o  = rem_i[WIDTH] | (shifted >= dsr_ext);
        rem_o   = qbit_o ? (shifted - dsr_ext) : shifted;
    end

endmodule

// File: rtl/seq_modulus.sv
// Multi-cycle unsigned modulus/divide unit, one quotient bit per clock.
// Optional macro SEQ_MODULUS_EARLY_EXIT_EN: Dividend<Divisor finishes without CALC.
module seq_modulus
    import seq_modulus_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Start,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Modulus,
    output logic [WIDTH-1:0] Quotient,
    output logic             DivByZero
);

`ifdef SEQ_MODULUS_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   rem_q, rem_d;
    // Dividend bits shift out of the top while quotient bits shift in at the bottom
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [WIDTH-1:0] mod_q, mod_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   step_rem;
    logic             step_qbit;

    mod_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_i  (rem_q),
        .bit_i  (dvd_q[WIDTH-1]),
        .dsr_i  (dsr_q),
        .rem_o  (step_rem),
        .qbit_o (step_qbit)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        mod_d   = mod_q;
        quo_d   = quo_q;
        dbz_d   = dbz_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (Start) begin
                    dvd_d = Dividend;
                    dsr_d = Divisor;
                    rem_d = '0;
                    cnt_d = CNT_W'(WIDTH);
                    dbz_d = 1'b0;
                    if (Divisor == '0) begin
                        state_d = ST_DONE;
                        dbz_d   = 1'b1;
                        mod_d   = Dividend;
                        quo_d   = '1;
                    end else if (EARLY_EXIT && (Dividend < Divisor)) begin
                        state_d = ST_DONE;
                        mod_d   = Dividend;
                        quo_d   = '0;
                    end else begin
                        state_d = ST_CALC;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_CALC: begin
                rem_d = step_rem;
                dvd_d = {dvd_q[WIDTH-2:0], step_qbit};
                cnt_d = cnt_q - 1'b1;
                // Final step: results are taken straight from the step outputs
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                    mod_d   = step_rem[WIDTH-1:0];
                    quo_d   = {dvd_q[WIDTH-2:0], step_qbit};
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            mod_q   <= '0;
            quo_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            mod_q   <= mod_d;
            quo_q   <= quo_d;
            dbz_q   <= dbz_d;
        end
    end

    assign Busy      = (state_q == ST_CALC);
    assign Done      = (state_q == ST_DONE);
    assign Modulus   = mod_q;
    assign Quotient  = quo_q;
    assign DivByZero = dbz_q;

endmodule

// File: tb/tb_seq_modulus.sv
// Directed bench for seq_modulus: a WIDTH=4 and a WIDTH=8 instance on one clock.
module tb_seq_modulus;

`ifdef SEQ_MODULUS_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       s4 = 1'b0;
    logic [3:0] dd4 = '0, dv4 = '0;
    logic       busy4, done4, dbz4;
    logic [3:0] mod4, quo4;

    logic       s8 = 1'b0;
    logic [7:0] dd8 = '0, dv8 = '0;
    logic       busy8, done8, dbz8;
    logic [7:0] mod8, quo8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_modulus #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .Start(s4), .Dividend(dd4), .Divisor(dv4),
        .Busy(busy4), .Done(done4), .Modulus(mod4), .Quotient(quo4), .DivByZero(dbz4)
    );

    seq_modulus #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .Start(s8), .Dividend(dd8), .Divisor(dv8),
        .Busy(busy8), .Done(done8), .Modulus(mod8), .Quotient(quo8), .DivByZero(dbz8)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] em;
        logic [7:0] eq;
        logic       edz;
        string      nm;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Runs one WIDTH=8 operation; poke>0 re-pulses Start with (1,1) at that cycle.
    task automatic op8(input vec_t v, input int poke);
        int lat, busy_n, elat;
        elat = (v.b == 0 || (EARLY && v.a < v.b)) ? 1 : 9;
        @(negedge clk);
        s8 = 1'b1; dd8 = v.a; dv8 = v.b;
        @(posedge clk); #1;
        s8 = 1'b0; dd8 = ~v.a; dv8 = ~v.b;
        lat = 1; busy_n = 0;
        @(negedge clk);
        while (!done8 && lat < 40) begin
            if (busy8) busy_n++;
            if (lat == poke) begin
                s8 = 1'b1; dd8 = 8'd1; dv8 = 8'd1;
                @(posedge clk); #1;
                s8 = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        chk({v.nm, " done"}, 32'(done8), 1);
        chk({v.nm, " latency"}, 32'(lat), 32'(elat));
        chk({v.nm, " busy_cycles"}, 32'(busy_n), (elat == 1) ? 0 : 8);
        chk({v.nm, " busy_at_done"}, 32'(busy8), 0);
        chk({v.nm, " modulus"}, 32'(mod8), 32'(v.em));
        chk({v.nm, " quotient"}, 32'(quo8), 32'(v.eq));
        chk({v.nm, " divbyzero"}, 32'(dbz8), 32'(v.edz));
        @(negedge clk);
        chk({v.nm, " done_pulse"}, 32'(done8), 0);
    endtask

    task automatic wait4(output int lat);
        lat = 1;
        @(negedge clk);
        while (!done4 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        vec_t vt[$];
        vec_t v;
        int lat, ndone;

        vt.push_back('{8'd200, 8'd7,   8'd4,   8'd28,  1'b0, "d200_7"});
        vt.push_back('{8'd5,   8'd9,   8'd5,   8'd0,   1'b0, "d5_9"});
        vt.push_back('{8'd0,   8'd5,   8'd0,   8'd0,   1'b0, "d0_5"});
        vt.push_back('{8'd255, 8'd255, 8'd0,   8'd1,   1'b0, "dmax_max"});
        vt.push_back('{8'd173, 8'd1,   8'd0,   8'd173, 1'b0, "d173_1"});
        vt.push_back('{8'd100, 8'd0,   8'd100, 8'd255, 1'b1, "d100_0"});
        vt.push_back('{8'd128, 8'd3,   8'd2,   8'd42,  1'b0, "d128_3"});
        vt.push_back('{8'd250, 8'd25,  8'd0,   8'd10,  1'b0, "d250_25"});
        vt.push_back('{8'd1,   8'd200, 8'd1,   8'd0,   1'b0, "d1_200"});

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst busy8", 32'(busy8), 0);
        chk("rst done8", 32'(done8), 0);
        chk("rst mod8", 32'(mod8), 0);
        chk("rst quo8", 32'(quo8), 0);
        chk("rst dbz8", 32'(dbz8), 0);
        chk("rst busy4", 32'(busy4), 0);
        chk("rst done4", 32'(done4), 0);
        rst_n = 1'b1;

        foreach (vt[i]) op8(vt[i], 0);

        repeat (3) @(negedge clk);
        chk("hold modulus", 32'(mod8), 1);
        chk("hold done", 32'(done8), 0);

        // Second Start during CALC must be ignored
        op8('{8'd200, 8'd7, 8'd4, 8'd28, 1'b0, "busy_start"}, 3);

        // Reset on the third CALC cycle aborts the operation
        @(negedge clk);
        s8 = 1'b1; dd8 = 8'd255; dv8 = 8'd16;
        @(posedge clk); #1;
        s8 = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort busy_before", 32'(busy8), 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort busy", 32'(busy8), 0);
        chk("abort done", 32'(done8), 0);
        chk("abort mod", 32'(mod8), 0);
        chk("abort quo", 32'(quo8), 0);
        chk("abort dbz", 32'(dbz8), 0);
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8) ndone++;
        end
        chk("abort no_done", 32'(ndone), 0);
        op8('{8'd255, 8'd16, 8'd15, 8'd15, 1'b0, "after_abort"}, 0);

        // WIDTH=4 single operation
        @(negedge clk);
        s4 = 1'b1; dd4 = 4'd8; dv4 = 4'd2;
        @(posedge clk); #1;
        s4 = 1'b0;
        wait4(lat);
        chk("w4 8_2 latency", 32'(lat), 5);
        chk("w4 8_2 mod", 32'(mod4), 0);
        chk("w4 8_2 quo", 32'(quo4), 4);
        chk("w4 8_2 dbz", 32'(dbz4), 0);

        // WIDTH=4 back-to-back with Start held through DONE
        @(negedge clk);
        s4 = 1'b1; dd4 = 4'd7; dv4 = 4'd3;
        @(posedge clk); #1;
        wait4(lat);
        chk("b2b 7_3 latency", 32'(lat), 5);
        chk("b2b 7_3 mod", 32'(mod4), 1);
        chk("b2b 7_3 quo", 32'(quo4), 2);
        dd4 = 4'd15; dv4 = 4'd4;
        @(posedge clk); #1;
        wait4(lat);
        chk("b2b 15_4 latency", 32'(lat), 5);
        chk("b2b 15_4 mod", 32'(mod4), 3);
        chk("b2b 15_4 quo", 32'(quo4), 3);
        dd4 = 4'd9; dv4 = 4'd3;
        @(posedge clk); #1;
        wait4(lat);
        chk("b2b 9_3 latency", 32'(lat), 5);
        chk("b2b 9_3 mod", 32'(mod4), 0);
        chk("b2b 9_3 quo", 32'(quo4), 3);
        s4 = 1'b0;
        @(negedge clk);
        chk("b2b end done", 32'(done4), 0);
        chk("b2b end busy", 32'(busy4), 0);

        // WIDTH=4 divide by zero
        @(negedge clk);
        s4 = 1'b1; dd4 = 4'd6; dv4 = 4'd0;
        @(posedge clk); #1;
        s4 = 1'b0;
        wait4(lat);
        chk("w4 dbz latency", 32'(lat), 1);
        chk("w4 dbz flag", 32'(dbz4), 1);
        chk("w4 dbz mod", 32'(mod4), 6);
        chk("w4 dbz quo", 32'(quo4), 15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
